regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Instruction-driven controller that issues reads and writes on the 8 x 16-bit register file port and consumes its registered Src/Dest read data. It accepts one instruction at a time over a valid/ready handshake. It executes load-immediate, move, add and output operations. It sits between the instruction source and the register file, owning the Addr_A/Addr_B/WR/Data_in side of that interface.

## Interface
- No parameters; data width is fixed at 16 and register count at 8.
- Reset: asynchronous, active-high.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous active-high reset. At top level the register file reset is driven by ~RST.
- Instr_valid  input  1  instruction present.
- Instr_ready  output  1  sequencer can accept an instruction.
- Opcode  input  2  00 LDI, 01 MOV, 10 ADD, 11 OUT.
- Rd  input  3  destination/first-operand register index.
- Rs  input  3  source register index.
- Imm  input  16  immediate for LDI.
- Addr_A  output  4  register file read address A; bit 3 always 0.
- Addr_B  output  4  register file read/write address B; bit 3 always 0.
- WR  output  1  register file write enable; write target is Addr_B.
- Data_in  output  16  register file write data.
- Src  input  16  register file registered read of Addr_A.
- Dest  input  16  register file registered read of Addr_B.
- Result  output  16  value of Rd captured by OUT.
- Result_valid  output  1  one-cycle pulse when Result updates.
- Carry  output  1  carry-out of the most recent ADD.

## Operation
- States: IDLE, ISSUE, EXEC, WRITE.
- Instr_ready is 1 only in IDLE.
- Handshake: an instruction is accepted on a rising edge where Instr_valid=1 and Instr_ready=1. Opcode, Rd, Rs and Imm are latched into internal registers at that edge.
- Instr_* inputs are ignored outside IDLE and may change freely.
- Register file outputs (Addr_A, Addr_B, WR, Data_in) are decoded only from the state and the latched fields. There is no combinational path from Instr_* to them.
- IDLE: WR=0; Addr_A and Addr_B hold their last values. On accept, go to WRITE if LDI, otherwise go to ISSUE.
- WRITE (LDI only): Addr_B={0,Rd}, Data_in=Imm, WR=1. Go to IDLE.
- ISSUE: Addr_A={0,Rs}, Addr_B={0,Rd}, WR=0. The register file samples both addresses at the end of this cycle. Go to EXEC.
- EXEC: Src and Dest are valid. Addr_A and Addr_B are held.
  - MOV: Data_in=Src, WR=1.
  - ADD: {carry,Data_in}=Dest+Src as a 17-bit sum; WR=1; Carry register loads the carry at the end of EXEC.
  - OUT: WR=0; Result loads Dest at the end of EXEC; Result_valid=1 in the following cycle only.
  - Go to IDLE.
- Arithmetic: ADD wraps modulo 2^16. Carry is unchanged by LDI, MOV and OUT.
- Rd==Rs:
  - MOV is a no-op write of the same value.
  - ADD doubles the register.
  - Both operands read the pre-write value, because the register file read returns the old data.
- Back-to-back instructions: the next instruction is accepted in the IDLE cycle after WRITE or EXEC. Its ISSUE reads the value written by the previous instruction, which is committed by then.
- Reset at any time: state goes to IDLE and WR=0 immediately, so no partial write occurs. All outputs go to their reset values and latched fields clear to 0.

## Timing
- Reset values: Instr_ready=1, Addr_A=0, Addr_B=0, WR=0, Data_in=0, Result=0, Result_valid=0, Carry=0.
- Cycle counts, counted from the accept edge:
  - LDI: 1 cycle in WRITE; write commits at edge +1; Instr_ready returns at edge +1.
  - MOV/ADD: ISSUE then EXEC; write commits at edge +2; Instr_ready returns at edge +2.
  - OUT: Result is valid and Result_valid=1 during the cycle after edge +2.
- Maximum throughput: 1 instruction per 2 cycles for LDI, 1 per 3 cycles otherwise.
- Instr_valid held high in IDLE is accepted on the first rising edge.

## Test plan
- Reset then LDI R3,0x1234, then OUT R3 -> WR high exactly one cycle with Addr_B=3 and Data_in=0x1234. Result=0x1234 with a single-cycle Result_valid 3 cycles after the OUT accept. Instr_ready low during execution.
- LDI R1,0xFFFF; LDI R2,0x0002; ADD R1,R2 (Rd=1, Rs=2); OUT R1 -> Result=0x0001, Carry=1. A following ADD of 0x0001+0x0001 clears Carry to 0.
- MOV R5,R1 after LDI R1,0xA5A5; ADD R5,R5 -> OUT R5 gives 0x4B4A and Carry=1 (0xA5A5 doubled).
- Instr_valid held high continuously with 4 queued instructions -> accepts occur only in IDLE cycles. Spacing is 2 cycles for LDI and 3 for others. No instruction is dropped or duplicated.
- Assert RST during EXEC of ADD R4,R6 -> WR drops in the same cycle, R4 is unchanged, and all outputs take their reset values. The next LDI executes normally.
- Toggle Instr_* randomly while not in IDLE -> no effect on Addr_A, Addr_B, WR or Data_in, and the executed result matches the latched instruction.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// Handshake and register-file bus between the instruction source, the sequencer and the register file.
// The master side is the environment (instruction source plus register file); the slave side is the sequencer.
interface regfile_sequencer_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADDR_W = 4;

    logic              Instr_valid;
    logic              Instr_ready;
    logic [1:0]        Opcode;
    logic [IDX_W-1:0]  Rd;
    logic [IDX_W-1:0]  Rs;
    logic [DATA_W-1:0] Imm;
    logic [ADDR_W-1:0] Addr_A;
    logic [ADDR_W-1:0] Addr_B;
    logic              WR;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Src;
    logic [DATA_W-1:0] Dest;
    logic [DATA_W-1:0] Result;
    logic              Result_valid;
    logic              Carry;

    modport master (
        output Instr_valid, Opcode, Rd, Rs, Imm, Src, Dest,
        input  Instr_ready, Addr_A, Addr_B, WR, Data_in, Result, Result_valid, Carry
    );

    modport slave (
        input  Instr_valid, Opcode, Rd, Rs, Imm, Src, Dest,
        output Instr_ready, Addr_A, Addr_B, WR, Data_in, Result, Result_valid, Carry
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Instruction sequencer driving an 8 x 16-bit register file: LDI, MOV, ADD and OUT.
// Register-file controls are decoded only from the state and the fields latched at accept.
module regfile_sequencer (
    input  logic               CLK,
    input  logic               RST,
    regfile_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADDR_W = 4;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WRITE} state_t;

    state_t            state;
    logic [1:0]        op;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W:0]   sum;
    logic              writes_back;

    always_comb begin
        sum         = {1'b0, bus.Dest} + {1'b0, bus.Src};
        writes_back = (op == OP_MOV) || (op == OP_ADD);
    end

    // Register-file side decode; addresses and data hold their last values when not driven.
    always_comb begin
        bus.Instr_ready = (state == IDLE);
        bus.Addr_A      = addr_a_q;
        bus.Addr_B      = addr_b_q;
        bus.WR          = 1'b0;
        bus.Data_in     = data_q;
        case (state)
            ISSUE: begin
                bus.Addr_A = {1'b0, rs};
                bus.Addr_B = {1'b0, rd};
            end
            WRITE: begin
                bus.Addr_B  = {1'b0, rd};
                bus.Data_in = imm;
                bus.WR      = 1'b1;
            end
            EXEC: begin
                bus.WR = writes_back;
                if (op == OP_MOV) begin
                    bus.Data_in = bus.Src;
                end else if (op == OP_ADD) begin
                    bus.Data_in = sum[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= IDLE;
            op               <= '0;
            rd               <= '0;
            rs               <= '0;
            imm              <= '0;
            addr_a_q         <= '0;
            addr_b_q         <= '0;
            data_q           <= '0;
            bus.Result       <= '0;
            bus.Result_valid <= 1'b0;
            bus.Carry        <= 1'b0;
        end else begin
            bus.Result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Instr_valid) begin
                        op    <= bus.Opcode;
                        rd    <= bus.Rd;
                        rs    <= bus.Rs;
                        imm   <= bus.Imm;
                        state <= (bus.Opcode == OP_LDI) ? WRITE : ISSUE;
                    end
                end
                WRITE: begin
                    addr_b_q <= {1'b0, rd};
                    data_q   <= imm;
                    state    <= IDLE;
                end
                ISSUE: begin
                    addr_a_q <= {1'b0, rs};
                    addr_b_q <= {1'b0, rd};
                    state    <= EXEC;
                end
                EXEC: begin
                    if (writes_back) begin
                        data_q <= bus.Data_in;
                    end
                    if (op == OP_ADD) begin
                        bus.Carry <= sum[DATA_W];
                    end
                    // Register file read data is valid this cycle; capture it for OUT.
                    if (op == OP_OUT) begin
                        bus.Result       <= bus.Dest;
                        bus.Result_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized self-checking bench for regfile_sequencer with a behavioural register-file reference model.
// The bench also plays the register file itself (registered reads, write on WR).
module tb_regfile_sequencer;
    localparam logic [1:0] LDI = 2'b00;
    localparam logic [1:0] MOV = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] OUT = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] imm;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sequencer_if bus ();

    regfile_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Environment register file: registered reads return pre-write data.
    logic [15:0] rf [8];
    always @(posedge clk) begin
        if (bus.WR) rf[bus.Addr_B[2:0]] <= bus.Data_in;
        bus.Src  <= rf[bus.Addr_A[2:0]];
        bus.Dest <= rf[bus.Addr_B[2:0]];
    end

    int unsigned cyc   = 0;
    int unsigned n_acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.Instr_valid && bus.Instr_ready) n_acc <= n_acc + 1;
    end

    logic [15:0] mref [8];
    logic        mcarry = 1'b0;
    logic [15:0] last_result = 16'h0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.Instr_valid = 1'b0;
        bus.Opcode      = 2'b00;
        bus.Rd          = 3'd0;
        bus.Rs          = 3'd0;
        bus.Imm         = 16'h0;
    endtask

    task automatic scramble();
        bus.Instr_valid = 1'($urandom);
        bus.Opcode      = 2'($urandom);
        bus.Rd          = 3'($urandom);
        bus.Rs          = 3'($urandom);
        bus.Imm         = 16'($urandom);
    endtask

    task automatic drive_ins(input ins_t i);
        bus.Opcode      = i.op;
        bus.Rd          = i.rd;
        bus.Rs          = i.rs;
        bus.Imm         = i.imm;
        bus.Instr_valid = 1'b1;
    endtask

    // Architectural effect of one instruction on the reference state.
    task automatic model_apply(input ins_t i);
        logic [16:0] s;
        s = 17'(mref[i.rd]) + 17'(mref[i.rs]);
        case (i.op)
            LDI: mref[i.rd] = i.imm;
            MOV: mref[i.rd] = mref[i.rs];
            ADD: begin
                mref[i.rd] = s[15:0];
                mcarry     = s[16];
            end
            default: ;
        endcase
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},  32'(bus.Instr_ready),  32'd1);
        check({tag, "_addr_a"}, 32'(bus.Addr_A),       32'd0);
        check({tag, "_addr_b"}, 32'(bus.Addr_B),       32'd0);
        check({tag, "_wr"},     32'(bus.WR),           32'd0);
        check({tag, "_data"},   32'(bus.Data_in),      32'd0);
        check({tag, "_result"}, 32'(bus.Result),       32'd0);
        check({tag, "_rvalid"}, 32'(bus.Result_valid), 32'd0);
        check({tag, "_carry"},  32'(bus.Carry),        32'd0);
    endtask

    // Issue one instruction from IDLE and check its whole execution window.
    task automatic exec(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [15:0] imm, input bit scr);
        ins_t        i;
        logic [16:0] s;
        logic [15:0] exp_w;
        logic [15:0] exp_res;
        logic        exp_c;
        int          lat;
        int          wr_cnt;
        i.op = op; i.rd = rd; i.rs = rs; i.imm = imm;
        s       = 17'(mref[rd]) + 17'(mref[rs]);
        exp_c   = mcarry;
        exp_res = mref[rd];
        case (op)
            LDI:     exp_w = imm;
            MOV:     exp_w = mref[rs];
            ADD:     begin exp_w = s[15:0]; exp_c = s[16]; end
            default: exp_w = 16'h0;
        endcase
        lat    = (op == LDI) ? 1 : 2;
        wr_cnt = 0;
        @(negedge clk);
        drive_ins(i);
        check("ready_idle", 32'(bus.Instr_ready), 32'd1);
        @(posedge clk);
        #1;
        if (scr) scramble(); else bus.Instr_valid = 1'b0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            check("ready_busy", 32'(bus.Instr_ready), 32'd0);
            if (op != LDI && c == 0) begin
                check("issue_addr_a", 32'(bus.Addr_A), 32'({1'b0, rs}));
                check("issue_addr_b", 32'(bus.Addr_B), 32'({1'b0, rd}));
            end
            if (bus.WR) begin
                wr_cnt++;
                check("wr_addr", 32'(bus.Addr_B),  32'({1'b0, rd}));
                check("wr_data", 32'(bus.Data_in), 32'(exp_w));
            end
            if (scr) scramble();
        end
        @(negedge clk);
        bus.Instr_valid = 1'b0;
        check("ready_back", 32'(bus.Instr_ready), 32'd1);
        check("wr_count", 32'(wr_cnt), (op == OUT) ? 32'd0 : 32'd1);
        if (op == OUT) begin
            check("result",       32'(bus.Result),       32'(exp_res));
            check("result_valid", 32'(bus.Result_valid), 32'd1);
            last_result = bus.Result;
        end else begin
            check("result_quiet", 32'(bus.Result_valid), 32'd0);
        end
        check("carry", 32'(bus.Carry), 32'(exp_c));
        model_apply(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t        q [4];
        int unsigned t_acc [4];
        int unsigned acc0;
        int          n;

        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        for (int r = 0; r < 8; r++) exec(LDI, 3'(r), 3'd0, 16'($urandom), 1'b0);

        exec(LDI, 3'd3, 3'd0, 16'h1234, 1'b0);
        exec(OUT, 3'd3, 3'd0, 16'h0, 1'b0);
        check("tp_ldi_out", 32'(last_result), 32'h1234);

        exec(LDI, 3'd1, 3'd0, 16'hFFFF, 1'b0);
        exec(LDI, 3'd2, 3'd0, 16'h0002, 1'b0);
        exec(ADD, 3'd1, 3'd2, 16'h0, 1'b0);
        exec(OUT, 3'd1, 3'd0, 16'h0, 1'b0);
        check("tp_add_wrap", 32'(last_result), 32'h0001);
        check("tp_add_carry", 32'(bus.Carry), 32'd1);
        exec(ADD, 3'd1, 3'd1, 16'h0, 1'b0);
        check("tp_carry_clear", 32'(bus.Carry), 32'd0);

        exec(LDI, 3'd1, 3'd0, 16'hA5A5, 1'b0);
        exec(MOV, 3'd5, 3'd1, 16'h0, 1'b0);
        exec(ADD, 3'd5, 3'd5, 16'h0, 1'b0);
        exec(OUT, 3'd5, 3'd0, 16'h0, 1'b0);
        check("tp_double", 32'(last_result), 32'h4B4A);
        check("tp_double_carry", 32'(bus.Carry), 32'd1);

        // Instr_valid held high across a queue of four instructions.
        q[0] = '{op: LDI, rd: 3'd0, rs: 3'd0, imm: 16'($urandom)};
        q[1] = '{op: MOV, rd: 3'd7, rs: 3'd0, imm: 16'h0};
        q[2] = '{op: LDI, rd: 3'd6, rs: 3'd0, imm: 16'($urandom)};
        q[3] = '{op: ADD, rd: 3'd7, rs: 3'd6, imm: 16'h0};
        acc0 = n_acc;
        @(negedge clk);
        drive_ins(q[0]);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.Instr_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_wait", 32'(n < 20), 32'd1);
            t_acc[k] = cyc;
            @(posedge clk);
            #1;
            if (k < 3) drive_ins(q[k+1]); else bus.Instr_valid = 1'b0;
        end
        for (int k = 0; k < 3; k++)
            check("b2b_spacing", t_acc[k+1] - t_acc[k], (q[k].op == LDI) ? 32'd2 : 32'd3);
        for (int k = 0; k < 4; k++) model_apply(q[k]);
        repeat (3) @(negedge clk);
        check("b2b_accepts", n_acc - acc0, 32'd4);
        exec(OUT, 3'd7, 3'd0, 16'h0, 1'b0);
        exec(OUT, 3'd0, 3'd0, 16'h0, 1'b0);

        // Reset in the middle of ADD R4,R6.
        exec(LDI, 3'd4, 3'd0, 16'h1111, 1'b0);
        exec(LDI, 3'd6, 3'd0, 16'h2222, 1'b0);
        @(negedge clk);
        q[0] = '{op: ADD, rd: 3'd4, rs: 3'd6, imm: 16'h0};
        drive_ins(q[0]);
        @(posedge clk);
        #1;
        bus.Instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_wr", 32'(bus.WR), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mcarry = 1'b0;
        check("rst_r4_kept", 32'(rf[4]), 32'(mref[4]));
        exec(LDI, 3'd4, 3'd0, 16'hBEEF, 1'b0);
        exec(OUT, 3'd4, 3'd0, 16'h0, 1'b0);
        check("rst_then_ldi", 32'(last_result), 32'hBEEF);

        // Random instructions with Instr_* toggled while busy.
        for (int r = 0; r < 60; r++)
            exec(2'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 1'b1);

        for (int r = 0; r < 8; r++) exec(OUT, 3'(r), 3'd0, 16'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
